// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch/realignment stage.
//   fetch_state_t : alignment state of the fetch stream
//   PARCEL_W      : width of one instruction parcel (halfword)
//   LEN32_CODE    : low two bits of a parcel that starts a 32-bit instruction
//   is_rvc()      : 1 when a parcel is a complete 16-bit (compressed) instruction
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_EMPTY = 2'd0,  // pc on a word boundary, nothing buffered
    FS_HALF  = 2'd1,  // pc on a halfword, residue_q holds the parcel at pc
    FS_ALIGN = 2'd2   // redirected to a halfword, loading the residue
  } fetch_state_t;

  localparam int PARCEL_W = 16;
  localparam logic [1:0] LEN32_CODE = 2'b11;

  // Length is decided by the low two bits only; masking keeps every parcel bit
  // referenced so callers can hand over the whole parcel.
  function automatic logic is_rvc(input logic [PARCEL_W-1:0] parcel);
    logic [PARCEL_W-1:0] len_mask;
    len_mask = {{(PARCEL_W-2){1'b0}}, LEN32_CODE};
    return (parcel & len_mask) != len_mask;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Instruction fetch/realignment stage sitting directly after program memory.
// Drives a word address, consumes same-cycle combinational read data, and
// carves 16-bit (RVC) and 32-bit instructions out of the halfword stream,
// including 32-bit instructions that straddle a word boundary.
//
// Build option: RVC_ALIGN_EN. When undefined, every word is a 32-bit
// instruction, there is no residue buffer and redirect_pc[1:0] is ignored.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   mem_addr   [31:0] out  word-aligned byte address to program memory
//   mem_rdata  [31:0] in   program memory data for mem_addr (same cycle)
//   redirect_valid    in   branch/jump redirect, beats everything else
//   redirect_pc [31:0] in  redirect target (bit 0 ignored)
//   out_valid / out_ready  instruction handshake towards decode
//   out_instr  [31:0] out  instruction, RVC zero-extended into [15:0]
//   out_pc     [31:0] out  byte PC of out_instr
//   out_is_compressed out  out_instr is a 16-bit instruction
//
// Handshake: out_valid/out_ready. An instruction transfers (fires) on a
// rising clk edge where both are 1. While out_valid=1 and out_ready=0 all
// outputs stay stable. out_valid never depends on out_ready.
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_compressed
);

  localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] word_base;
  logic        fire;

  assign word_base = {pc_q[31:2], 2'b00};
  assign out_pc    = pc_q;

`ifdef RVC_ALIGN_EN

  fetch_state_t        state_q, state_d;
  logic [PARCEL_W-1:0] residue_q, residue_d;
  logic                cur_rvc;
  logic [31:0]         instr_raw;

  always_comb begin
    mem_addr          = word_base;
    cur_rvc           = 1'b0;
    instr_raw         = '0;
    // reset_n gating keeps out_valid low while reset is asserted.
    out_valid         = reset_n & ~redirect_valid & (state_q != FS_ALIGN);
    out_instr         = '0;
    out_is_compressed = 1'b0;

    case (state_q)
      FS_EMPTY: begin
        cur_rvc   = is_rvc(mem_rdata[15:0]);
        instr_raw = cur_rvc ? {16'h0000, mem_rdata[15:0]} : mem_rdata;
      end
      FS_HALF: begin
        // The residue is the low parcel; the next word supplies the rest.
        mem_addr  = word_base + 32'd4;
        cur_rvc   = is_rvc(residue_q);
        instr_raw = cur_rvc ? {16'h0000, residue_q} : {mem_rdata[15:0], residue_q};
      end
      default: ;
    endcase

    if (out_valid) begin
      out_instr         = instr_raw;
      out_is_compressed = cur_rvc;
    end
    fire = out_valid & out_ready;

    pc_d      = pc_q;
    state_d   = state_q;
    residue_d = residue_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFE;
      residue_d = '0;
      state_d   = redirect_pc[1] ? FS_ALIGN : FS_EMPTY;
    end else begin
      case (state_q)
        FS_ALIGN: begin
          residue_d = mem_rdata[31:16];
          state_d   = FS_HALF;
        end
        FS_EMPTY: begin
          if (fire) begin
            if (cur_rvc) begin
              pc_d      = pc_q + 32'd2;
              residue_d = mem_rdata[31:16];
              state_d   = FS_HALF;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        FS_HALF: begin
          if (fire) begin
            if (cur_rvc) begin
              pc_d    = pc_q + 32'd2;
              state_d = FS_EMPTY;
            end else begin
              // Straddling instruction consumed; upper half becomes the residue.
              pc_d      = pc_q + 32'd4;
              residue_d = mem_rdata[31:16];
            end
          end
        end
        default: state_d = FS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC_W;
      state_q   <= FS_EMPTY;
      residue_q <= '0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      residue_q <= residue_d;
    end
  end

`else

  always_comb begin
    mem_addr          = word_base;
    out_valid         = reset_n & ~redirect_valid;
    out_instr         = out_valid ? mem_rdata : 32'h0000_0000;
    out_is_compressed = 1'b0;
    fire              = out_valid & out_ready;

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC_W;
    end else begin
      pc_q <= pc_d;
    end
  end

`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: directed stimulus with hand-computed expectations.
// Expected instructions go into exp_q; an independent monitor pops and
// compares on every fire. Expectations follow the RVC_ALIGN_EN build setting.
module tb_fetch_aligner;

  logic        clk;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_compressed;

  logic [31:0] mem [0:63];
  logic [64:0] exp_q[$];  // {pc, instr, compressed}
  int          checks;
  int          errors;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .out_is_compressed (out_is_compressed)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every fire must match the oldest expected instruction.
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fire got pc=%h instr=%h expected=none", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        check("fire_pc", out_pc, e[64:33]);
        check("fire_instr", out_instr, e[32:1]);
        check("fire_is_c", {31'b0, out_is_compressed}, {31'b0, e[0]});
      end
    end
  end

  // ---------------- driver tasks (start/end just after posedge) ----------------
  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic c);
    exp_q.push_back({pc, instr, c});
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] pc, input logic rdy);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    out_ready      = rdy;
    @(negedge clk);
    check("redirect_valid_low", {31'b0, out_valid}, 32'd0);
    check("redirect_instr_zero", out_instr, 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_is_c", {31'b0, out_is_compressed}, 32'd0);
    check("rst_pc", out_pc, 32'h0000_0000);
    check("rst_addr", mem_addr, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0000_0093;
    mem[1]  = 32'h448d_4415;
    mem[4]  = 32'h00a0_0093;
    mem[7]  = 32'ha603_438c;
    mem[8]  = 32'h86aa_ffc7;
    mem[9]  = 32'hc699_8e91;
    mem[10] = 32'h0040_0513;

    @(posedge clk); #1;
    do_reset();

    // Mixed 32-bit / RVC words from reset.
    push(32'h0, 32'h0000_0093, 1'b0);
`ifdef RVC_ALIGN_EN
    push(32'h4, 32'h0000_4415, 1'b1);
    push(32'h6, 32'h0000_448d, 1'b1);
`else
    push(32'h4, 32'h448d_4415, 1'b0);
`endif
    drain();
    @(negedge clk);
    check("next_pc_after_words", out_pc, 32'h8);
    check("next_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Redirect coinciding with out_ready: instruction at 0x4 is squashed.
    do_reset();
    push(32'h0, 32'h0000_0093, 1'b0);
    drain();
    redirect(32'h10, 1'b1);
    push(32'h10, 32'h00a0_0093, 1'b0);
    drain();

    // Word-straddling instruction plus a 3-cycle stall on it.
    redirect(32'h1C, 1'b0);
`ifdef RVC_ALIGN_EN
    push(32'h1C, 32'h0000_438c, 1'b1);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_instr", out_instr, 32'hffc7_a603);
      check("stall_pc", out_pc, 32'h1E);
      check("stall_addr", mem_addr, 32'h20);
      @(posedge clk); #1;
    end
    push(32'h1E, 32'hffc7_a603, 1'b0);
    push(32'h22, 32'h0000_86aa, 1'b1);
`else
    push(32'h1C, 32'ha603_438c, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_instr", out_instr, 32'h86aa_ffc7);
      check("stall_pc", out_pc, 32'h20);
      check("stall_addr", mem_addr, 32'h20);
      @(posedge clk); #1;
    end
    push(32'h20, 32'h86aa_ffc7, 1'b0);
`endif
    drain();

    // Redirect onto a halfword: one alignment bubble with RVC support.
    redirect(32'h26, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
`ifdef RVC_ALIGN_EN
    check("align_bubble", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    push(32'h26, 32'h0000_c699, 1'b1);
`else
    check("no_bubble", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    push(32'h24, 32'hc699_8e91, 1'b0);
`endif
    push(32'h28, 32'h0040_0513, 1'b0);
    drain();

    // Reset in the middle of the stream, then restart at RESET_PC.
    redirect(32'h1C, 1'b0);
`ifdef RVC_ALIGN_EN
    push(32'h1C, 32'h0000_438c, 1'b1);
`else
    push(32'h1C, 32'ha603_438c, 1'b0);
`endif
    drain();
    do_reset();
    push(32'h0, 32'h0000_0093, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
